hs32_decode_q: RTL and testbench

- Parametrised successor decode stage for the HS32 core: sits between fetch and execute.
- Accepts 32-bit instruction words plus PC over a valid/ready handshake.
- Classifies each word by prefix bits [31:28] into one of five formats and splits it into uniform execute fields.
- Buffers decoded results in a DEPTH-entry queue so fetch and execute stalls are decoupled without dropping or duplicating instructions.

---
 rtl/hs32_dec_pkg.sv | 81 ++++++++
 rtl/hs32_decode_fifo.sv | 67 ++++++
 rtl/hs32_decode_q.sv | 78 +++++++
 tb/tb_hs32_decode_q.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/hs32_dec_pkg.sv
// HS32 decode stage shared types: format codes, field widths, decoded entry, decode function.
// Optional build macro: HS32_DECODE_ILLEGAL_TRAP_EN (consumed by hs32_decode_q).
package hs32_dec_pkg;

  localparam int unsigned INSN_W  = 32;
  localparam int unsigned FMT_W   = 3;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned RIDX_W  = 4;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned IMM_W   = 24;
  localparam int unsigned CTL_W   = 12;

  localparam logic [FMT_W-1:0] FMT_IMM16   = 3'd0;
  localparam logic [FMT_W-1:0] FMT_SHIFT   = 3'd1;
  localparam logic [FMT_W-1:0] FMT_IMM24   = 3'd2;
  localparam logic [FMT_W-1:0] FMT_REG     = 3'd3;
  localparam logic [FMT_W-1:0] FMT_JUMP    = 3'd4;
  localparam logic [FMT_W-1:0] FMT_ILLEGAL = 3'd7;

  typedef struct packed {
    logic [FMT_W-1:0]   fmt;
    logic [ALUOP_W-1:0] aluop;
    logic [RIDX_W-1:0]  regdst;
    logic [RIDX_W-1:0]  regsrc;
    logic [RIDX_W-1:0]  regopd;
    logic [SHAMT_W-1:0] shift;
    logic [IMM_W-1:0]   imm;
    logic [CTL_W-1:0]   ctlsig;
    logic               illegal;
  } dec_entry_t;

  // Split an instruction word into uniform execute fields; unused fields stay 0.
  function automatic dec_entry_t hs32_decode(input logic [INSN_W-1:0] w);
    dec_entry_t d;
    d = '0;
    case (w[31:28])
      4'd0: begin
        d.fmt    = FMT_IMM16;
        d.aluop  = w[27:24];
        d.regdst = w[23:20];
        d.regsrc = w[19:16];
        d.imm    = {8'b0, w[15:0]};
      end
      4'd1: begin
        d.fmt    = FMT_SHIFT;
        d.aluop  = w[27:24];
        d.regdst = w[23:20];
        d.regsrc = w[19:16];
        d.regopd = w[15:12];
        d.shift  = w[11:7];
        d.ctlsig = {5'b0, w[6:0]};
      end
      4'd2: begin
        d.fmt    = FMT_IMM24;
        d.ctlsig = {8'b0, w[27:24]};
        d.imm    = w[23:0];
      end
      4'd3: begin
        d.fmt    = FMT_REG;
        d.aluop  = w[27:24];
        d.regdst = w[23:20];
        d.regsrc = w[19:16];
        d.regopd = w[15:12];
        d.ctlsig = w[11:0];
      end
      4'd4: begin
        d.fmt    = FMT_JUMP;
        d.ctlsig = {8'b0, w[27:24]};
        d.regdst = w[23:20];
        d.aluop  = w[19:16];
        d.imm    = {8'b0, w[15:0]};
      end
      default: begin
        d.fmt     = FMT_ILLEGAL;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hs32_decode_fifo.sv
// Generic synchronous FIFO with registered head output, flush and async active-low reset.
// The head register holds its last value while the queue is empty.
module hs32_decode_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             ready,
  output logic             valid
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr, wptr_n, rptr_n;
  logic [CW-1:0]    count, count_n;
  logic [WIDTH-1:0] head_n;
  logic             do_push, do_pop;

  // Next pointers, occupancy and head; a push into an empty queue becomes the head directly.
  always_comb begin
    do_push = push && ready;
    do_pop  = pop && valid;
    wptr_n  = wptr + AW'(do_push);
    rptr_n  = rptr + AW'(do_pop);
    count_n = count + CW'(do_push) - CW'(do_pop);
    head_n  = rdata;
    if (count_n != '0) begin
      head_n = (do_push && (rptr_n == wptr)) ? wdata : mem[rptr_n];
    end
  end

  // Storage, pointers, flags and head register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
      ready <= 1'b1;
      valid <= 1'b0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ready <= 1'b1;
      valid <= 1'b0;
    end else begin
      if (do_push) mem[wptr] <= wdata;
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      count <= count_n;
      rdata <= head_n;
      ready <= (count_n != CW'(DEPTH));
      valid <= (count_n != '0);
    end
  end

endmodule

// File: rtl/hs32_decode_q.sv
// HS32 decode stage: classifies instruction words and queues decoded fields for execute.
// Optional build macro: HS32_DECODE_ILLEGAL_TRAP_EN -- when defined, illegal words are queued
// and flagged; otherwise they are accepted and dropped, and illegal stays 0.
module hs32_decode_q
  import hs32_dec_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [INSN_W-1:0]   instd,
  input  logic [PC_W-1:0]     pc_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [FMT_W-1:0]    fmt,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [RIDX_W-1:0]   regdst,
  output logic [RIDX_W-1:0]   regsrc,
  output logic [RIDX_W-1:0]   regopd,
  output logic [SHAMT_W-1:0]  shift,
  output logic [IMM_W-1:0]    imm,
  output logic [CTL_W-1:0]    ctlsig,
  output logic                illegal,
  output logic [PC_W-1:0]     pc_o
);

  localparam int unsigned ENT_W = $bits(dec_entry_t);
  localparam int unsigned Q_W   = ENT_W + PC_W;

  dec_entry_t       dec_c;
  dec_entry_t       head;
  logic             keep_c;
  logic             push_c;
  logic [Q_W-1:0]   qdata;

  // Decode ahead of the queue write; decide whether the word is kept.
  always_comb begin
    dec_c = hs32_decode(instd);
`ifdef HS32_DECODE_ILLEGAL_TRAP_EN
    keep_c = 1'b1;
`else
    keep_c = !dec_c.illegal;
    dec_c.illegal = 1'b0;
`endif
    push_c = valid_i && ready_o && keep_c;
  end

  hs32_decode_fifo #(
    .WIDTH (Q_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push_c),
    .pop   (ready_i),
    .wdata ({dec_c, pc_i}),
    .rdata (qdata),
    .ready (ready_o),
    .valid (valid_o)
  );

  assign {head, pc_o} = qdata;
  assign fmt     = head.fmt;
  assign aluop   = head.aluop;
  assign regdst  = head.regdst;
  assign regsrc  = head.regsrc;
  assign regopd  = head.regopd;
  assign shift   = head.shift;
  assign imm     = head.imm;
  assign ctlsig  = head.ctlsig;
  assign illegal = head.illegal;

endmodule

// File: tb/tb_hs32_decode_q.sv
// Directed bench for hs32_decode_q (DEPTH=2, PC_W=32).
module tb_hs32_decode_q;

  logic        clk = 1'b0;
  logic        reset, flush, valid_i, ready_i;
  logic        ready_o, valid_o, illegal;
  logic [31:0] instd, pc_i, pc_o;
  logic [2:0]  fmt;
  logic [3:0]  aluop, regdst, regsrc, regopd;
  logic [4:0]  shift;
  logic [23:0] imm;
  logic [11:0] ctlsig;

  int checks = 0;
  int errors = 0;

  hs32_decode_q #(.DEPTH(2), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_i(valid_i), .ready_o(ready_o),
    .instd(instd), .pc_i(pc_i), .valid_o(valid_o), .ready_i(ready_i),
    .fmt(fmt), .aluop(aluop), .regdst(regdst), .regsrc(regsrc), .regopd(regopd),
    .shift(shift), .imm(imm), .ctlsig(ctlsig), .illegal(illegal), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    instd = '0; pc_i = '0;
    #2;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_fmt", 32'(fmt), 0);
    chk("rst_imm", 32'(imm), 0);
    chk("rst_pc", pc_o, 0);
    step(); step();
    reset = 1'b1;
    step();
    chk("rst_ready", 32'(ready_o), 1);

    // IMM16
    valid_i = 1; instd = 32'h0312ABCD; pc_i = 32'h100; ready_i = 1;
    step();
    valid_i = 0;
    chk("imm16_valid", 32'(valid_o), 1);
    chk("imm16_fmt", 32'(fmt), 0);
    chk("imm16_aluop", 32'(aluop), 3);
    chk("imm16_rd", 32'(regdst), 1);
    chk("imm16_rm", 32'(regsrc), 2);
    chk("imm16_imm", 32'(imm), 32'h00ABCD);
    chk("imm16_pc", pc_o, 32'h100);
    step();
    chk("empty_valid", 32'(valid_o), 0);
    chk("empty_hold_imm", 32'(imm), 32'h00ABCD);
    chk("empty_hold_pc", pc_o, 32'h100);

    // SHIFT
    valid_i = 1; instd = 32'h1A5698C5; pc_i = 32'h104;
    step();
    valid_i = 0;
    chk("shift_fmt", 32'(fmt), 1);
    chk("shift_aluop", 32'(aluop), 32'hA);
    chk("shift_rd", 32'(regdst), 5);
    chk("shift_rm", 32'(regsrc), 6);
    chk("shift_rn", 32'(regopd), 9);
    chk("shift_sh", 32'(shift), 32'h11);
    chk("shift_ctl", 32'(ctlsig), 32'h045);
    chk("shift_imm", 32'(imm), 0);
    step();

    // Back-pressure: three words into a two-entry queue
    ready_i = 0;
    valid_i = 1; instd = 32'h2ABCDEF0; pc_i = 32'h200;
    step();
    chk("bp_ready1", 32'(ready_o), 1);
    instd = 32'h3456789A; pc_i = 32'h204;
    step();
    chk("bp_full_ready", 32'(ready_o), 0);
    instd = 32'h4123ABCD; pc_i = 32'h208;
    step();
    chk("bp_stall_ready", 32'(ready_o), 0);
    chk("bp_stall_pc", pc_o, 32'h200);
    chk("bp_a_fmt", 32'(fmt), 2);
    chk("bp_a_ctl", 32'(ctlsig), 32'hA);
    chk("bp_a_imm", 32'(imm), 32'hBCDEF0);
    ready_i = 1;
    step();
    chk("bp_b_pc", pc_o, 32'h204);
    chk("bp_b_ready", 32'(ready_o), 1);
    chk("bp_b_fmt", 32'(fmt), 3);
    chk("bp_b_aluop", 32'(aluop), 4);
    chk("bp_b_rd", 32'(regdst), 5);
    chk("bp_b_rm", 32'(regsrc), 6);
    chk("bp_b_rn", 32'(regopd), 7);
    chk("bp_b_ctl", 32'(ctlsig), 32'h89A);
    step();
    valid_i = 0;
    chk("bp_c_pc", pc_o, 32'h208);
    chk("bp_c_valid", 32'(valid_o), 1);
    chk("bp_c_fmt", 32'(fmt), 4);
    chk("bp_c_ctl", 32'(ctlsig), 1);
    chk("bp_c_rd", 32'(regdst), 2);
    chk("bp_c_aluop", 32'(aluop), 3);
    chk("bp_c_imm", 32'(imm), 32'hABCD);
    step();
    chk("bp_drained", 32'(valid_o), 0);

    // Flush with two entries queued and a concurrent push/pop
    ready_i = 0;
    valid_i = 1; instd = 32'h0312ABCD; pc_i = 32'h300;
    step();
    instd = 32'h1A5698C5; pc_i = 32'h304;
    step();
    chk("fl_full", 32'(ready_o), 0);
    flush = 1; ready_i = 1; instd = 32'h0FFFFFFF; pc_i = 32'h308;
    step();
    flush = 0; valid_i = 0;
    chk("fl_valid", 32'(valid_o), 0);
    chk("fl_ready", 32'(ready_o), 1);
    step();
    chk("fl_not_queued", 32'(valid_o), 0);

    // Illegal prefix
    valid_i = 1; instd = 32'h90000000; pc_i = 32'h400;
    chk("ill_ready", 32'(ready_o), 1);
    step();
    valid_i = 0;
`ifdef HS32_DECODE_ILLEGAL_TRAP_EN
    chk("ill_valid", 32'(valid_o), 1);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_fmt", 32'(fmt), 7);
    chk("ill_pc", pc_o, 32'h400);
    chk("ill_aluop", 32'(aluop), 0);
`else
    chk("ill_valid", 32'(valid_o), 0);
    chk("ill_flag", 32'(illegal), 0);
`endif
    step();
    valid_i = 1; instd = 32'h0312ABCD; pc_i = 32'h404;
    step();
    valid_i = 0;
    chk("post_ill_valid", 32'(valid_o), 1);
    chk("post_ill_pc", pc_o, 32'h404);
    chk("post_ill_flag", 32'(illegal), 0);
    step();

    // Reset mid-stream with two entries queued
    ready_i = 0;
    valid_i = 1; instd = 32'h1A5698C5; pc_i = 32'h500;
    step();
    pc_i = 32'h504;
    step();
    valid_i = 0;
    chk("mr_valid_pre", 32'(valid_o), 1);
    #2 reset = 1'b0;
    #1;
    chk("mr_valid", 32'(valid_o), 0);
    chk("mr_fmt", 32'(fmt), 0);
    chk("mr_aluop", 32'(aluop), 0);
    chk("mr_shift", 32'(shift), 0);
    chk("mr_ctl", 32'(ctlsig), 0);
    chk("mr_pc", pc_o, 0);
    step();
    reset = 1'b1;
    step();
    chk("mr_ready", 32'(ready_o), 1);
    chk("mr_valid_post", 32'(valid_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
